imm_ext_sequencer: RTL

Pipelined immediate-generation stage for the ID stage of the MIPS datapath. Decodes the opcode of each incoming instruction and selects the extension mode: sign, zero, LUI, or branch-offset. Produces the 32-bit immediate through a 2-stage valid/ready pipeline with full backpressure, flush, and a wrap-around issue counter. It replaces the ad-hoc per-opcode extension muxing in the decode stage.

---
 rtl/imm_ext_pkg.sv | 59 +++++
 rtl/imm_ext_unit.sv | 21 ++
 rtl/imm_ext_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for immediate generation: extension modes, opcodes, decode table.
package imm_ext_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'd0,
        EXT_ZERO   = 2'd1,
        EXT_LUI    = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_e;

    localparam logic [OP_W-1:0] OP_RTYPE  = 6'h00;
    localparam logic [OP_W-1:0] OP_REGIMM = 6'h01;
    localparam logic [OP_W-1:0] OP_J      = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL    = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE    = 6'h05;
    localparam logic [OP_W-1:0] OP_BLEZ   = 6'h06;
    localparam logic [OP_W-1:0] OP_BGTZ   = 6'h07;
    localparam logic [OP_W-1:0] OP_ADDI   = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU  = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI   = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU  = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI   = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI    = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI   = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI    = 6'h0F;
    localparam logic [OP_W-1:0] OP_LB     = 6'h20;
    localparam logic [OP_W-1:0] OP_SW     = 6'h2B;

    // Decoded S1 payload
    typedef struct packed {
        logic [IMM_W-1:0] imm16;
        ext_mode_e        mode;
        logic             used;
    } dec_t;

    // Opcode -> extension mode; unknown opcodes fall back to the configured default
    function automatic dec_t decode_op(input logic [OP_W-1:0]  op,
                                       input logic [IMM_W-1:0] imm16,
                                       input logic             force_sign);
        dec_t d;
        d.imm16 = imm16;
        d.used  = 1'b1;
        d.mode  = force_sign ? EXT_SIGN : EXT_ZERO;
        case (op) inside
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, [OP_LB:OP_SW]: d.mode = EXT_SIGN;
            OP_ANDI, OP_ORI, OP_XORI:                            d.mode = EXT_ZERO;
            OP_LUI:                                              d.mode = EXT_LUI;
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:         d.mode = EXT_BRANCH;
            default:                                             d.used = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational 16-bit immediate extender for all MIPS extension modes.
module imm_ext_unit
    import imm_ext_pkg::*;
(
    input  logic [IMM_W-1:0]  i_imm16,
    input  ext_mode_e         i_mode,
    output logic [WORD_W-1:0] o_imm
);

    // Select the extension form for the requested mode
    always_comb begin
        o_imm = {{16{i_imm16[15]}}, i_imm16};
        case (i_mode)
            EXT_ZERO:   o_imm = {16'h0000, i_imm16};
            EXT_LUI:    o_imm = {i_imm16, 16'h0000};
            EXT_BRANCH: o_imm = {{14{i_imm16[15]}}, i_imm16, 2'b00};
            default:    o_imm = {{16{i_imm16[15]}}, i_imm16};
        endcase
    end

endmodule

// File: rtl/imm_ext_sequencer.sv
// Two-stage decode/extend pipeline producing the ID-stage immediate with valid/ready flow control.
module imm_ext_sequencer
    import imm_ext_pkg::*;
#(
    parameter int unsigned CNT_W              = 16,
    parameter bit          FORCE_SIGN_DEFAULT = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] imm_out,
    output logic [1:0]        ext_mode,
    output logic              imm_used,
    output logic [CNT_W-1:0]  ext_count
);

    logic              r_s1_valid;
    dec_t              r_s1;
    logic              r_s2_valid;
    logic [WORD_W-1:0] r_imm_out;
    logic [1:0]        r_ext_mode;
    logic              r_imm_used;
    logic [CNT_W-1:0]  r_ext_count;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_in_fire;
    logic              w_out_fire;
    dec_t              w_dec;
    logic [WORD_W-1:0] w_ext_imm;
    logic              w_unused;

    assign w_s2_adv   = !r_s2_valid || out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign in_ready   = w_s1_adv && !flush;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_s2_valid && out_ready;
    assign w_dec      = decode_op(instr[31:26], instr[15:0], FORCE_SIGN_DEFAULT);
    assign w_unused   = ^instr[25:16];

    imm_ext_unit u_ext (
        .i_imm16 (r_s1.imm16),
        .i_mode  (r_s1.mode),
        .o_imm   (w_ext_imm)
    );

    // Stage occupancy; flush empties both stages
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s2_adv) r_s2_valid <= r_s1_valid;
            if (w_s1_adv) r_s1_valid <= in_valid;
        end
    end

    // S1 decode payload
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_s1 <= '{imm16: '0, mode: EXT_SIGN, used: 1'b0};
        end else if (w_in_fire) begin
            r_s1 <= w_dec;
        end
    end

    // S2 extended result, held while the consumer stalls
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_imm_out  <= '0;
            r_ext_mode <= 2'd0;
            r_imm_used <= 1'b0;
        end else if (w_s2_adv && r_s1_valid) begin
            r_imm_out  <= w_ext_imm;
            r_ext_mode <= r_s1.mode;
            r_imm_used <= r_s1.used;
        end
    end

    // Completed output handshakes, wrapping; counts even when flush coincides
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_ext_count <= '0;
        end else if (w_out_fire) begin
            r_ext_count <= r_ext_count + CNT_W'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign imm_out   = r_imm_out;
    assign ext_mode  = r_ext_mode;
    assign imm_used  = r_imm_used;
    assign ext_count = r_ext_count;

endmodule
